// File: rtl/pdh_capture_ctrl.sv
// pdh_capture_ctrl
// Triggered, decimated circular capture buffer. Samples from din_i are written
// into an internal block RAM every N cycles. A programmable number of
// pre-trigger samples is kept ahead of the trigger sample. Readback is rotated
// so that logical index 0 is always the oldest sample of the record.
//
// Optional feature (macro PDH_CAPTURE_TIMESTAMP_EN):
//   A 32-bit free-running write-tick counter. Its value at the trigger sample
//   is latched into trig_ts_o. When the macro is absent, trig_ts_o is tied to 0.
//
// Ports:
//   pdh_clk, rst_ni : clock, async active-low reset
//   arm_i           : rising edge starts a capture (honoured only in IDLE)
//   abort_i         : level, cancels a capture in progress
//   trig_i          : rising edge is the trigger event (honoured in ARMED)
//   din_i           : sample stream
//   pretrig_i       : pre-trigger sample count, latched at arm
//   decimation_i    : write one sample every N cycles, latched at arm (0 -> 1)
//   raddr_i         : logical read index (0 = oldest)
//   rdata_o         : registered read data, 1-cycle latency
//   ready_o         : idle and accepting arm
//   valid_o         : a complete record is held
//   done_o          : one-cycle pulse on record completion
//   trig_ts_o       : trigger timestamp
module pdh_capture_ctrl #(
  parameter int DW    = 64,
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH),
  parameter int DECW  = 22
) (
  input  logic            pdh_clk,
  input  logic            rst_ni,
  input  logic            arm_i,
  input  logic            abort_i,
  input  logic            trig_i,
  input  logic [DW-1:0]   din_i,
  input  logic [AW-1:0]   pretrig_i,
  input  logic [DECW-1:0] decimation_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o,
  output logic            ready_o,
  output logic            valid_o,
  output logic            done_o,
  output logic [31:0]     trig_ts_o
);

  typedef enum logic [1:0] {IDLE, PRE, ARMED, POST} state_t;

  localparam logic [AW-1:0] PMAX = AW'(DEPTH - 1);

  state_t          state, state_nxt;
  logic            arm_q, trig_q;
  logic [AW-1:0]   wp, pretrig, taddr, start, post_cnt;
  logic [DECW-1:0] dec_n, dec_cnt;
  logic            trig_pend;
  logic            we, trig_hit, complete;

  logic [DW-1:0]   mem [DEPTH];

  wire arm_edge  = arm_i & ~arm_q;
  wire trig_edge = trig_i & ~trig_q;
  wire tick      = (state != IDLE) && (dec_cnt == '0);

  assign ready_o = (state == IDLE);

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    trig_hit  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE:  if (arm_edge) state_nxt = PRE;
      // wp doubles as the PRE sample count because it is cleared at arm.
      PRE: begin
        if (wp == pretrig) state_nxt = ARMED;
        else if (tick) begin
          we = 1'b1;
          if (wp + AW'(1) == pretrig) state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (tick) begin
          we = 1'b1;
          if (trig_pend || trig_edge) begin
            trig_hit = 1'b1;
            // With the maximum pre-trigger depth the trigger sample is the last one.
            if (pretrig == PMAX) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = POST;
            end
          end
        end
      end
      POST: begin
        if (tick) begin
          we = 1'b1;
          if (post_cnt == AW'(1)) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && abort_i) begin
      state_nxt = IDLE;
      we        = 1'b0;
      trig_hit  = 1'b0;
      complete  = 1'b0;
    end
  end

  always_ff @(posedge pdh_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      arm_q     <= 1'b0;
      trig_q    <= 1'b0;
      wp        <= '0;
      pretrig   <= '0;
      taddr     <= '0;
      start     <= '0;
      post_cnt  <= '0;
      dec_n     <= DECW'(1);
      dec_cnt   <= '0;
      trig_pend <= 1'b0;
      valid_o   <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      arm_q  <= arm_i;
      trig_q <= trig_i;
      state  <= state_nxt;
      done_o <= complete;
      if (state == IDLE && arm_edge) begin
        pretrig <= (pretrig_i > PMAX) ? PMAX : pretrig_i;
        dec_n   <= (decimation_i == '0) ? DECW'(1) : decimation_i;
        dec_cnt <= '0;
        wp      <= '0;
        valid_o <= 1'b0;
      end else begin
        if (state != IDLE)
          dec_cnt <= (dec_cnt == dec_n - DECW'(1)) ? '0 : dec_cnt + DECW'(1);
        if (we) wp <= wp + AW'(1);
      end
      // Edges seen outside ARMED are dropped rather than queued.
      trig_pend <= (state == ARMED) && (trig_pend || trig_edge) && !trig_hit;
      // post_cnt holds the writes still owed after the current one.
      if (trig_hit) begin
        taddr    <= wp;
        post_cnt <= PMAX - pretrig;
      end else if (state == POST && we) begin
        post_cnt <= post_cnt - AW'(1);
      end
      if (complete) begin
        valid_o <= 1'b1;
        start   <= (trig_hit ? wp : taddr) - pretrig;
      end
    end
  end

  always_ff @(posedge pdh_clk) begin
    if (we) mem[wp] <= din_i;
  end

  // Registered read at the rotated address; a same-address write returns old data.
  always_ff @(posedge pdh_clk or negedge rst_ni) begin
    if (!rst_ni) rdata_o <= '0;
    else         rdata_o <= mem[start + raddr_i];
  end

`ifdef PDH_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt, trig_ts;
  always_ff @(posedge pdh_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      if (tick)     ts_cnt  <= ts_cnt + 32'd1;
      if (trig_hit) trig_ts <= ts_cnt;
    end
  end
  assign trig_ts_o = trig_ts;
`else
  assign trig_ts_o = '0;
`endif

endmodule

// File: tb/tb_pdh_capture_ctrl.sv
module tb_pdh_capture_ctrl;
  localparam int DW = 32, DEPTH = 16, AW = 4, DECW = 22;

  logic            pdh_clk = 1'b0;
  logic            rst_ni, arm_i, abort_i, trig_i;
  logic [DW-1:0]   din_i;
  logic [AW-1:0]   pretrig_i, raddr_i;
  logic [DECW-1:0] decimation_i;
  logic [DW-1:0]   rdata_o;
  logic            ready_o, valid_o, done_o;
  logic [31:0]     trig_ts_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  pdh_capture_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .DECW(DECW)) dut (
    .pdh_clk(pdh_clk), .rst_ni(rst_ni), .arm_i(arm_i), .abort_i(abort_i),
    .trig_i(trig_i), .din_i(din_i), .pretrig_i(pretrig_i),
    .decimation_i(decimation_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .ready_o(ready_o), .valid_o(valid_o), .done_o(done_o), .trig_ts_o(trig_ts_o)
  );

  always #5 pdh_clk = ~pdh_clk;
  always @(posedge pdh_clk) cyc <= cyc + 1;

  // Sample value is a recognisable function of the cycle it was presented in.
  function automatic logic [DW-1:0] f(input int c);
    logic [15:0] x;
    x = c[15:0];
    return {x, x ^ 16'hA5C3};
  endfunction

  always_comb din_i = f(cyc);

  task automatic step();
    @(posedge pdh_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int armed_off(input int n, input int p);
    int ne, pe;
    ne = (n == 0) ? 1 : n;
    pe = (p > DEPTH - 1) ? DEPTH - 1 : p;
    return (pe > 0) ? (pe - 1) * ne + 2 : 2;
  endfunction

  // mode 0: plain capture, 1: arm pulse during POST, 2: abort+arm on the
  // completion cycle, 3: reset during POST.
  task automatic run(input string tag, input int n, input int p, input int toff,
                     input int mode, output int kt);
    int ta, tt, ne, pe, done_exp, done_at, dcnt;
    ne = (n == 0) ? 1 : n;
    pe = (p > DEPTH - 1) ? DEPTH - 1 : p;
    pretrig_i    = p[AW-1:0];
    decimation_i = n[DECW-1:0];
    ta = cyc;
    chk({tag, "_ready_idle"}, ready_o, 1);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk({tag, "_ready_busy"}, ready_o, 0);
    tt = ta + toff;
    while (cyc < tt) step();
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    // Writes land at ta+1+k*ne; the trigger sample is the first at or after tt.
    kt = (tt - ta - 1 + ne - 1) / ne;
    done_exp = ta + 1 + (kt + DEPTH - 1 - pe) * ne + 1;
    if (mode == 1) begin
      while (cyc < done_exp - 3) step();
      arm_i = 1'b1;
      step();
      arm_i = 1'b0;
    end
    if (mode == 2) begin
      while (cyc < done_exp - 1) step();
      abort_i = 1'b1;
      arm_i   = 1'b1;
      step();
      chk({tag, "_abort_ready"}, ready_o, 1);
      chk({tag, "_abort_valid"}, valid_o, 0);
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
        if (done_o) dcnt++;
        step();
        abort_i = 1'b0;
        arm_i   = 1'b0;
      end
      chk({tag, "_abort_nodone"}, dcnt, 0);
      return;
    end
    if (mode == 3) begin
      while (cyc < done_exp - 5) step();
      rst_ni = 1'b0;
      #1;
      chk({tag, "_rst_ready"}, ready_o, 1);
      chk({tag, "_rst_valid"}, valid_o, 0);
      chk({tag, "_rst_done"}, done_o, 0);
      chk({tag, "_rst_rdata"}, rdata_o, 0);
      chk({tag, "_rst_ts"}, trig_ts_o, 0);
      step();
      step();
      rst_ni = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
        if (done_o) dcnt++;
        step();
      end
      chk({tag, "_rst_nodone"}, dcnt, 0);
      return;
    end
    done_at = -1;
    while (done_at < 0 && cyc <= done_exp + 20) begin
      if (done_o) done_at = cyc;
      step();
    end
    chk({tag, "_done_cycle"}, done_at, done_exp);
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_valid"}, valid_o, 1);
    for (int i = 0; i < DEPTH; i++) begin
      raddr_i = i[AW-1:0];
      step();
      chk($sformatf("%s_rd%0d", tag, i), rdata_o, f(ta + 1 + (kt - pe + i) * ne));
    end
  endtask

  initial begin
    int kt, n, p, ta, dcnt;
    rst_ni = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0;
    pretrig_i = '0; decimation_i = '0; raddr_i = '0;
    step();
    step();
    chk("reset_ready", ready_o, 1);
    chk("reset_valid", valid_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_ts", trig_ts_o, 0);
    rst_ni = 1'b1;
    step();

    run("n1p4", 1, 4, 10, 1, kt);
    run("n3p0", 3, 0, 5, 0, kt);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 3);
      p = $urandom_range(0, 15);
      run($sformatf("rnd%0d", r), n, p, armed_off(n, p) + $urandom_range(0, 12), 0, kt);
    end

    // Trigger edge while still in PRE must be dropped.
    pretrig_i = 4'd8; decimation_i = 22'd1;
    ta = cyc;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    while (cyc < ta + 3) step();
    trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_o) dcnt++;
      step();
    end
    chk("pretrig_nodone", dcnt, 0);
    chk("pretrig_busy", ready_o, 0);
    chk("pretrig_valid", valid_o, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("pretrig_abort_ready", ready_o, 1);
    chk("pretrig_abort_valid", valid_o, 0);
    step();

    run("abort", 1, 4, 10, 2, kt);
    run("rstmid", 1, 4, 10, 3, kt);
    n = $urandom_range(1, 3);
    p = $urandom_range(0, 15);
    run("after_rst", n, p, armed_off(n, p) + $urandom_range(0, 8), 0, kt);

    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    run("clamp", 2, 31, armed_off(2, 31) + 7, 0, kt);
`ifdef PDH_CAPTURE_TIMESTAMP_EN
    chk("clamp_ts", trig_ts_o, kt);
`else
    chk("clamp_ts", trig_ts_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pdh_capture_ctrl.md
# pdh_capture_ctrl

Triggered, decimated circular capture buffer for the PDH core: the next generation of the single-shot BRAM capture controller. Records a parametrised-width sample stream into an internal single-clock block RAM with a programmable pre-trigger depth, so the software-visible record holds samples before and after a trigger event. Readback is rotated so that logical address 0 is always the oldest sample. Sits between the PDH datapath (`din_i`) and the AXI register/readout logic, all in the `pdh_clk` domain.

## Interface
- `DW`, 64: sample width in bits.
- `DEPTH`, 16384: record length in samples; must be a power of two, at least 4.
- `AW`, $clog2(DEPTH): address width.
- `DECW`, 22: decimation code width.
- `pdh_clk` in 1: single clock for all logic, memory write and read.
- `rst_ni` in 1: asynchronous, active-low reset.
- `arm_i` in 1: capture request; its rising edge starts a capture.
- `abort_i` in 1: level; cancels a capture in progress.
- `trig_i` in 1: trigger; its rising edge is the trigger event.
- `din_i` in DW: sample stream, one candidate sample per cycle.
- `pretrig_i` in AW: number of pre-trigger samples, sampled at arm; values above DEPTH-1 are clamped to DEPTH-1.
- `decimation_i` in DECW: write one sample every N cycles, sampled at arm; 0 is treated as 1.
- `raddr_i` in AW: logical read index, where 0 is the oldest sample.
- `rdata_o` out DW: read data, registered.
- `ready_o` out 1: idle and accepting `arm_i`.
- `valid_o` out 1: a complete record is held in memory.
- `done_o` out 1: one-cycle pulse when a record completes.
- `trig_ts_o` out 32: trigger timestamp (see Configuration).

## Operation
- States: IDLE, PRE, ARMED, POST.
- IDLE -> PRE on a rising edge of `arm_i` (edge detected against the registered previous value).
  - Latches `pretrig_i` and `decimation_i`.
  - Clears `valid_o`, the write pointer `wp` and the decimation counter.
- Write tick: the decimation counter equals 0. The counter counts 0..N-1 and wraps. On a tick, `din_i` is written at `wp` and `wp` increments mod DEPTH.
- PRE: writes ticks until `pretrig` samples are stored, then goes to ARMED. If `pretrig` is 0, PRE lasts exactly one cycle and writes nothing.
  - Trigger edges in PRE are ignored, not queued.
- ARMED: keeps writing on ticks, wrapping `wp` circularly.
  - A rising edge of `trig_i` sets `trig_pend`.
  - The first tick with `trig_pend` set, including a tick in the same cycle as the edge, is the trigger sample. Its address is latched as `taddr`, the state goes to POST, and the post-counter loads `DEPTH-pretrig`, which counts the trigger sample.
- POST: writes ticks and decrements the post-counter on each write.
  - When the counter reaches 0 after its final write: go to IDLE, pulse `done_o`, set `valid_o`, latch `start = taddr - pretrig` (mod DEPTH).
- Readback: physical address = `start + raddr_i` (mod DEPTH). Logical index `pretrig` is therefore the trigger sample.
- `abort_i` in any non-IDLE state:
  - next state IDLE; `valid_o` stays 0; no `done_o`; `start` unchanged.
  - `abort_i` takes priority over `arm_i`, `trig_i` and completion in the same cycle.
- `arm_i` edges outside IDLE are ignored.
- Reads during capture return current memory contents at the rotated address; data is meaningful only when `valid_o`=1.

## Timing
- Reset values: state IDLE, `ready_o`=1, `valid_o`=0, `done_o`=0, `rdata_o`=0, `trig_ts_o`=0, `start`=0, `taddr`=0, all counters 0.
- The arm edge at cycle t gives state PRE at t+1. The first write happens at t+1 (counter 0).
- `ready_o`=1 only in IDLE, deasserting in the cycle after the arm edge.
- `done_o` rises in the same cycle that the state returns to IDLE and `valid_o` rises.
- The final sample is written in the cycle before `done_o`.
- Read latency is 1 cycle: `raddr_i` at t gives `rdata_o` at t+1. A write and a read to the same physical address in the same cycle return the old data.
- Decimation N: consecutive writes are exactly N cycles apart. Trigger-to-trigger-sample latency is at most N-1 cycles.

## Configuration
- `PDH_CAPTURE_TIMESTAMP_EN` defined:
  - a 32-bit free-running tick counter runs from reset, wrapping and incrementing on every write tick;
  - its value at the trigger sample is latched into `trig_ts_o`, which holds until the next trigger sample.
- Not defined: no counter is built and `trig_ts_o` is tied to 0.

## Test plan
- DEPTH=16, N=1, pretrig=4, `din_i`=cycle count, trigger 10 cycles after the arm edge.
  - Required: `done_o` 12 cycles after the trigger sample.
  - `rdata_o` at logical 4 equals the trigger-sample value.
  - Logical 0..15 are monotonically consecutive.
- N=3, pretrig=0, trigger at arm+5.
  - Required: writes spaced exactly 3 cycles apart.
  - 16 samples are captured from the first tick at or after the trigger.
  - `done_o` 46 cycles after the trigger sample.
- Trigger edge during PRE, then no further trigger.
  - Required: the state stays ARMED indefinitely, with no `done_o`.
  - `abort_i` then gives IDLE next cycle, `valid_o`=0.
- `arm_i`, `abort_i` and a completion event in the same cycle.
  - Required: the state is IDLE, `valid_o`=0, no `done_o`.
  - `arm_i` edges during POST are ignored.
- `rst_ni` low mid-POST.
  - Required: all outputs return to their reset values immediately, with no `done_o` after release.
  - A subsequent arm captures normally.
- `pretrig_i`=31 with DEPTH=16 (clamped to 15), with `PDH_CAPTURE_TIMESTAMP_EN` defined.
  - Required: logical 15 is the trigger sample.
  - `trig_ts_o` equals the count of ticks before the trigger sample.
